// File: rtl/vga_sync_ctrl_if.sv
// Raster/pixel bundle between the VGA timing generator and the pixel selector / DAC pins.
// The master side drives the raster position, the syncs and the colour; the slave side returns rgb_in.
interface vga_sync_ctrl_if;
  logic [7:0] rgb_in;
  logic [9:0] x_ptr;
  logic [9:0] y_ptr;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       frame_tick;

  modport master (
    input  rgb_in,
    output x_ptr, y_ptr, pix_en, hsync, vsync, video_on,
    output red, green, blue, frame_tick
  );

  modport slave (
    output rgb_in,
    input  x_ptr, y_ptr, pix_en, hsync, vsync, video_on,
    input  red, green, blue, frame_tick
  );
endinterface

// File: rtl/vga_sync_ctrl.sv
// VGA raster timing generator. It owns the pixel position and registers the returned colour
// together with the syncs, so that colour and sync change on the same pixel boundary.
module vga_sync_ctrl #(
  parameter int DIV       = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_sync_ctrl_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             von_q, von_d;
  logic [7:0]       rgb_q, rgb_d;

  logic pix_en;
  logic h_last;
  logic v_last;
  logic vis;

  // pix_en is a pure decode of the divider register, so it never glitches on inputs.
  assign pix_en = (div_q == DIV_LAST);
  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);
  assign vis    = (h_q < H_VIS) && (v_q < V_VIS);

  always_comb begin
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    h_d     = h_q;
    v_d     = v_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    von_d   = von_q;
    rgb_d   = rgb_q;

    if (pix_en) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end

      // Output stage samples the pre-increment position: one pixel period of latency.
      hsync_d = !((h_q >= HS_START) && (h_q < HS_END));
      vsync_d = !((v_q >= VS_START) && (v_q < VS_END));
      von_d   = vis;
      rgb_d   = vis ? vga.rgb_in : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      von_q   <= 1'b0;
      rgb_q   <= 8'h00;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      von_q   <= von_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vga.x_ptr      = h_q;
  assign vga.y_ptr      = v_q;
  assign vga.pix_en     = pix_en;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = von_q;
  assign vga.red        = rgb_q[7:5];
  assign vga.green      = rgb_q[4:2];
  assign vga.blue       = rgb_q[1:0];
  assign vga.frame_tick = pix_en && h_last && v_last;

endmodule
